// File: rtl/clk_div_scheduler_if.sv
// Configuration port of clk_div_scheduler: valid/ready request plus a done/err completion pulse.
// The requester uses the master modport and the divider uses the slave modport.
interface clk_div_scheduler_if #(
   parameter int NCH = 4,
   parameter int DW  = 16
);
   localparam int CHW = $clog2(NCH) + 1;

   logic           cfg_valid;
   logic           cfg_ready;
   logic [CHW-1:0] cfg_ch;
   logic [DW-1:0]  cfg_div;
   logic           cfg_done;
   logic           cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_div,
      input  cfg_ready, cfg_done, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div,
      output cfg_ready, cfg_done, cfg_err
   );
endinterface

// File: rtl/clk_div_scheduler.sv
// Multi-channel programmable clock-enable generator; divisor updates land on period boundaries.
// Optional `CLK_DIV_GATE_EN adds ch_run[NCH-1:0] to freeze individual channels.
module clk_div_scheduler #(
   parameter int NCH         = 4,
   parameter int DW          = 16,
   parameter int DEFAULT_DIV = 32
) (
   input  logic                org_clk,
   input  logic                sys_rst_n,
`ifdef CLK_DIV_GATE_EN
   input  logic [NCH-1:0]      ch_run,
`endif
   clk_div_scheduler_if.slave  cfg,
   output logic [NCH-1:0]      div_tick,
   output logic [NCH-1:0]      div_level
);

   localparam int             CHW     = $clog2(NCH) + 1;
   localparam logic [CHW-1:0] NCH_LIM = CHW'(NCH);
   localparam logic [DW-1:0]  DIV_RST = DW'(DEFAULT_DIV);
   localparam logic [DW-1:0]  DIV_MIN = DW'(2);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [CHW-1:0] r_ch;
   logic [DW-1:0]  r_div_req;
   logic [DW-1:0]  w_div_clamp;
   logic           w_accept;
   logic           w_ready;
   logic           w_done;
   logic           w_err;

   logic [DW-1:0]  r_cnt     [NCH];
   logic [DW-1:0]  r_div     [NCH];
   logic [DW-1:0]  w_cnt_nxt [NCH];
   logic [DW-1:0]  w_div_nxt [NCH];
   logic [NCH-1:0] r_tick;
   logic [NCH-1:0] r_level;
   logic [NCH-1:0] w_run;
   logic [NCH-1:0] w_apply;

`ifdef CLK_DIV_GATE_EN
   assign w_run = ch_run;
`else
   assign w_run = '1;
`endif

   assign w_div_clamp = (cfg.cfg_div < DIV_MIN) ? DIV_MIN : cfg.cfg_div;

   // A stopped channel never reaches its wrap, so a pending update applies immediately.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         // NOTE: every combinational output gets a default first so no path infers a latch.
         w_apply[i]   = 1'b0;
         w_cnt_nxt[i] = r_cnt[i];
         w_div_nxt[i] = r_div[i];
         if ((r_state == ST_PEND) && (r_ch == CHW'(i)) &&
             ((r_cnt[i] == r_div[i] - DW'(1)) || !w_run[i])) begin
            w_apply[i]   = 1'b1;
            w_cnt_nxt[i] = '0;
            w_div_nxt[i] = r_div_req;
         end else if (w_run[i]) begin
            w_cnt_nxt[i] = (r_cnt[i] == r_div[i] - DW'(1)) ? '0 : r_cnt[i] + DW'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ready = 1'b1;
            if (cfg.cfg_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = (cfg.cfg_ch < NCH_LIM) ? ST_PEND : ST_ERR;
            end
         end
         ST_PEND: begin
            if (|w_apply) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            w_done      = 1'b1;
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge org_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state   <= ST_IDLE;
         r_ch      <= '0;
         r_div_req <= DIV_RST;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_ch      <= cfg.cfg_ch;
            r_div_req <= w_div_clamp;
         end
      end
   end

   // Tick and level are registered from the next-state count so the outputs come straight off flops.
   always_ff @(posedge org_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i] <= '0;
            r_div[i] <= DIV_RST;
         end
         r_tick  <= '0;
         r_level <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i]   <= w_cnt_nxt[i];
            r_div[i]   <= w_div_nxt[i];
            r_tick[i]  <= (w_cnt_nxt[i] == w_div_nxt[i] - DW'(1));
            r_level[i] <= (w_cnt_nxt[i] >= (w_div_nxt[i] >> 1));
         end
      end
   end

   assign div_tick      = r_tick & w_run;
   assign div_level     = r_level;
   assign cfg.cfg_ready = w_ready;
   assign cfg.cfg_done  = w_done;
   assign cfg.cfg_err   = w_err;

endmodule
